// File: rtl/ping_pong_monitor.sv
// Passive checker for a ping-pong counter: predicts the next (out, direction)
// from the sampled value and controls, flags mismatches and counts turnarounds.
module ping_pong_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] out,
    input  logic             direction,
    output logic             synced,
    output logic             err,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] turn_cnt
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_out_q, exp_out_d;
    logic             exp_dir_q, exp_dir_d;
    logic             prev_dir_q, prev_dir_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;

    logic [WIDTH-1:0] pred_out;
    logic             pred_dir;
    logic             step_dir;
    logic             mismatch;

    // Value the counter should show after this edge, given what it shows now.
    always_comb begin
        pred_out = out;
        pred_dir = direction;
        step_dir = direction ^ flip;
        if (enable && (max > min)) begin
            if ((out < min) || (out > max)) begin
                pred_out = min;
                pred_dir = 1'b1;
            end else begin
                if (out == max) begin
                    step_dir = 1'b0;
                end else if (out == min) begin
                    step_dir = 1'b1;
                end
                pred_dir = step_dir;
                pred_out = step_dir ? (out + ONE) : (out - ONE);
            end
        end
    end

    assign mismatch = (out != exp_out_q) || (direction != exp_dir_q);

    always_comb begin
        state_d     = state_q;
        exp_out_d   = pred_out;
        exp_dir_d   = pred_dir;
        prev_dir_d  = direction;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        if (clr) begin
            state_d    = UNSYNC;
            err_cnt_d  = '0;
            turn_cnt_d = '0;
        end else begin
            case (state_q)
                UNSYNC: state_d = TRACK;
                default: begin
                    // Prediction is reloaded every edge, so one bad sample costs one error.
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        state_d     = FAULT;
                    end
                    if (direction != prev_dir_q) begin
                        turn_cnt_d = sat_inc(turn_cnt_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNSYNC;
            exp_out_q   <= '0;
            exp_dir_q   <= 1'b0;
            prev_dir_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            turn_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_out_q   <= exp_out_d;
            exp_dir_q   <= exp_dir_d;
            prev_dir_q  <= prev_dir_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    assign synced    = (state_q != UNSYNC);
    assign err       = (state_q == FAULT);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign turn_cnt  = turn_cnt_q;

endmodule
